// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
//
// Loads one ccff configuration scan chain from a stream of decrypted
// bitstream words, then verifies it. A valid/ready word stream is unpacked
// LSB first and shifted bit-serially into the chain head. The chain is then
// rotated once with config_readback high. CRC-8 signatures of the loaded
// bits and of the bits returned at the tail are compared. The result is a
// sticky done or error flag.
//
// Ports
//   prog_clk         in   programming clock, all state on the rising edge
//   pReset_n         in   asynchronous active-low reset
//   start            in   one-cycle pulse, honoured in IDLE/DONE/ERROR only
//   abort            in   synchronous abort back to IDLE (wins over all)
//   s_data[DATA_W]   in   bitstream word, bit 0 shifted first
//   s_valid          in   s_data valid
//   s_ready          out  word accepted when s_valid & s_ready
//   ccff_head        out  serial configuration data into the chain
//   ccff_tail        in   serial data out of the chain
//   config_enable    out  chain shifts on every prog_clk edge where high
//   config_readback  out  high while the chain is rotated for verification
//   busy             out  loading or verifying
//   done             out  sticky: last load verified OK
//   error            out  sticky: CRC mismatch on last load
//   bit_count[CNT_W] out  bits shifted in the current phase
// ---------------------------------------------------------------------------
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 4,
    parameter int DATA_W    = 8
) (
    input  logic                           prog_clk,
    input  logic                           pReset_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic [DATA_W-1:0]              s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic                           ccff_head,
    input  logic                           ccff_tail,
    output logic                           config_enable,
    output logic                           config_readback,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int BC_W  = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // One step of CRC-8 (poly 0x07, MSB-first register) over a single bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb        = crc[7] ^ din;
        crc8_step = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    state_t             r_state;
    logic [DATA_W-1:0]  r_buf;        // word being unpacked, next bit in [0]
    logic [BC_W-1:0]    r_buf_cnt;    // bits still waiting in r_buf
    logic [CNT_W-1:0]   r_bit_count;
    logic               r_head;
    logic               r_cfg_en;
    logic               r_readback;
    logic               r_done;
    logic               r_error;
    logic [7:0]         r_crc_load;
    logic [7:0]         r_crc_rb;

    logic               w_pop;
    logic [CNT_W-1:0]   w_cnt_after;
    logic               w_ready;
    logic               w_accept;
    logic [7:0]         w_crc_rb_next;

    // Per-cycle pop/accept decisions and readback CRC update.
    always_comb begin
        w_pop         = 1'b0;
        w_cnt_after   = r_bit_count;
        w_ready       = 1'b0;
        w_accept      = 1'b0;
        w_crc_rb_next = crc8_step(r_crc_rb, ccff_tail);

        if (r_state == ST_LOAD) begin
            w_pop = (r_buf_cnt != {BC_W{1'b0}}) && (r_bit_count < LEN_C);
        end else begin
            w_pop = 1'b0;
        end

        w_cnt_after = r_bit_count + CNT_W'(w_pop);

        // A new word may land in the same cycle the last buffered bit pops,
        // but never once the chain is full after this cycle's pop.
        if ((r_state == ST_LOAD) && !abort && (w_cnt_after < LEN_C) &&
            ((r_buf_cnt == {BC_W{1'b0}}) || ((r_buf_cnt == BC_W'(1)) && w_pop))) begin
            w_ready = 1'b1;
        end else begin
            w_ready = 1'b0;
        end

        w_accept = w_ready && s_valid;
    end

    // Sequencer: load, verify, and result bookkeeping.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_state     <= ST_IDLE;
            r_buf       <= {DATA_W{1'b0}};
            r_buf_cnt   <= {BC_W{1'b0}};
            r_bit_count <= {CNT_W{1'b0}};
            r_head      <= 1'b0;
            r_cfg_en    <= 1'b0;
            r_readback  <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_crc_load  <= 8'h00;
            r_crc_rb    <= 8'h00;
        end else if (abort) begin
            // Chain contents are left undefined; done/error are untouched.
            r_state    <= ST_IDLE;
            r_buf      <= {DATA_W{1'b0}};
            r_buf_cnt  <= {BC_W{1'b0}};
            r_head     <= 1'b0;
            r_cfg_en   <= 1'b0;
            r_readback <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        r_state     <= ST_LOAD;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_bit_count <= {CNT_W{1'b0}};
                        r_crc_load  <= 8'h00;
                        r_crc_rb    <= 8'h00;
                        r_buf       <= {DATA_W{1'b0}};
                        r_buf_cnt   <= {BC_W{1'b0}};
                    end else begin
                        r_state <= r_state;
                    end
                end

                ST_LOAD: begin
                    if (r_bit_count == LEN_C) begin
                        // The last loaded bit is on ccff_head this cycle;
                        // enable stays high straight into the rotation.
                        r_state     <= ST_VERIFY;
                        r_bit_count <= {CNT_W{1'b0}};
                        r_buf       <= {DATA_W{1'b0}};
                        r_buf_cnt   <= {BC_W{1'b0}};
                        r_head      <= 1'b0;
                        r_cfg_en    <= 1'b1;
                        r_readback  <= 1'b1;
                    end else begin
                        if (w_pop) begin
                            r_head      <= r_buf[0];
                            r_cfg_en    <= 1'b1;
                            r_bit_count <= w_cnt_after;
                            r_crc_load  <= crc8_step(r_crc_load, r_buf[0]);
                        end else begin
                            // Starved: hold the chain rather than shift a bubble.
                            r_head   <= 1'b0;
                            r_cfg_en <= 1'b0;
                        end

                        if (w_accept) begin
                            r_buf     <= s_data;
                            r_buf_cnt <= BC_W'(DATA_W);
                        end else if (w_pop) begin
                            r_buf     <= r_buf >> 1;
                            r_buf_cnt <= r_buf_cnt - BC_W'(1);
                        end else begin
                            r_buf     <= r_buf;
                            r_buf_cnt <= r_buf_cnt;
                        end
                    end
                end

                ST_VERIFY: begin
                    r_crc_rb <= w_crc_rb_next;
                    if (r_bit_count == LEN_M1) begin
                        // Decide on the final readback bit directly.
                        r_bit_count <= LEN_C;
                        r_cfg_en    <= 1'b0;
                        r_readback  <= 1'b0;
                        if (w_crc_rb_next == r_crc_load) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end
                    end else begin
                        r_bit_count <= r_bit_count + CNT_W'(1);
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_cfg_en   <= 1'b0;
                    r_readback <= 1'b0;
                end
            endcase
        end
    end

    // During readback the chain output is looped straight back to its input.
    assign ccff_head       = r_readback ? ccff_tail : r_head;
    assign s_ready         = w_ready;
    assign config_enable   = r_cfg_en;
    assign config_readback = r_readback;
    assign busy            = (r_state == ST_LOAD) || (r_state == ST_VERIFY);
    assign done            = r_done;
    assign error           = r_error;
    assign bit_count       = r_bit_count;

endmodule
